// File: rtl/x2c_wr_ctrl.sv
// ---------------------------------------------------------------------------
// x2c_wr_ctrl
//
// Admission and write controller between the 10G serial-to-parallel converter
// and the X2C data/ctrl FIFO plus byte-count FIFO.
//
// At the first 256-bit word of each packet, the block decides whether to pass
// or drop the packet. A packet is admitted only when all of these hold:
//   - the link is up;
//   - the byte-count FIFO is not full;
//   - the data FIFO has at least MAX_PKT_WORDS free words.
// Because that reservation is made once, at admission, an admitted packet can
// never overflow either FIFO.
//
// Once a packet is admitted:
//   - Words beyond MAX_PKT_WORDS are discarded and the packet is flagged as
//     truncated.
//   - If the link is lost mid-packet, the packet is closed with an
//     error-flagged byte count. The rest of that packet, including its own
//     late byte count, is then dropped.
//
// Optional feature: define X2C_STATS_EN to add the pass_cnt/trunc_cnt
// statistics outputs.
//
// Parameters
//   MAX_PKT_WORDS  max words per packet and the admission free-space reserve
//   FREE_W         width of the data-FIFO free-word count
//
// Ports
//   clk          clock
//   reset_       asynchronous active-low reset
//   linkup       link status from the converter
//   s_we         word valid from the converter
//   s_data       256-bit parallel data
//   s_ctrl       32-bit parallel ctrl
//   s_bcnt_we    byte-count valid (end of packet)
//   s_byte_cnt   byte count: [15:0] bytes, [31:24] sof lane code
//   d_free       data/ctrl FIFO free words
//   b_full       byte-count FIFO full
//   d_we         data/ctrl FIFO write enable
//   d_dout       data to FIFO (follows s_data every cycle)
//   c_dout       ctrl to FIFO (follows s_ctrl every cycle)
//   b_we         byte-count FIFO write enable
//   b_din        byte count to FIFO: bit16 = truncated, bit17 = link error
//   drop_cnt     dropped packets, saturating
//   busy         controller is inside a packet (state != IDLE)
//   pass_cnt     [X2C_STATS_EN] cleanly written packets, wrapping
//   trunc_cnt    [X2C_STATS_EN] truncated or aborted packets, saturating
//
// State table
//   state  | meaning
//   IDLE   | between packets; the next word decides pass or drop
//   PASS   | admitted packet in progress; words are written to the FIFO
//   ABORT  | link lost mid-packet; write the error byte count (one cycle)
//   DROP   | discard words until the packet's byte count arrives
// ---------------------------------------------------------------------------
module x2c_wr_ctrl #(
    parameter int MAX_PKT_WORDS = 48,
    parameter int FREE_W        = 9
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              linkup,
    input  logic              s_we,
    input  logic [255:0]      s_data,
    input  logic [31:0]       s_ctrl,
    input  logic              s_bcnt_we,
    input  logic [31:0]       s_byte_cnt,
    input  logic [FREE_W-1:0] d_free,
    input  logic              b_full,
    output logic              d_we,
    output logic [255:0]      d_dout,
    output logic [31:0]       c_dout,
    output logic              b_we,
    output logic [31:0]       b_din,
    output logic [15:0]       drop_cnt,
    output logic              busy
`ifdef X2C_STATS_EN
    ,
    output logic [31:0]       pass_cnt,
    output logic [15:0]       trunc_cnt
`endif
);

    localparam int WCNT_W = $clog2(MAX_PKT_WORDS + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PASS  = 2'd1;
    localparam logic [1:0] ST_ABORT = 2'd2;
    localparam logic [1:0] ST_DROP  = 2'd3;

    localparam logic [FREE_W-1:0] FREE_RESV = FREE_W'(MAX_PKT_WORDS);
    localparam logic [WCNT_W-1:0] WCNT_MAX  = WCNT_W'(MAX_PKT_WORDS);
    localparam logic [31:0]       BIT_TRUNC = 32'h0001_0000;
    localparam logic [31:0]       BIT_LERR  = 32'h0002_0000;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [WCNT_W-1:0] wcnt;
    logic [WCNT_W-1:0] wcnt_nxt;
    logic              trunc;
    logic              trunc_nxt;
    logic              trunc_w;
    logic              d_we_nxt;
    logic              b_we_nxt;
    logic [31:0]       b_din_nxt;
    logic              drop_inc;
    logic              admit;
    logic              word_room;

    assign admit     = s_we & linkup & ~b_full & (d_free >= FREE_RESV);
    assign word_room = (wcnt < WCNT_MAX);

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        trunc_nxt = trunc;
        trunc_w   = trunc;
        d_we_nxt  = 1'b0;
        b_we_nxt  = 1'b0;
        b_din_nxt = b_din;
        drop_inc  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (s_we) begin
                    if (admit) begin
                        d_we_nxt = 1'b1;
                        if (s_bcnt_we) begin
                            // Single-word packet: admitted and closed in one cycle.
                            b_we_nxt  = 1'b1;
                            b_din_nxt = s_byte_cnt & ~BIT_TRUNC;
                            wcnt_nxt  = '0;
                        end else begin
                            state_nxt = ST_PASS;
                            wcnt_nxt  = WCNT_W'(1);
                        end
                    end else if (s_bcnt_we) begin
                        drop_inc = 1'b1;
                    end else begin
                        state_nxt = ST_DROP;
                    end
                end
            end

            ST_PASS: begin
                // A word arriving together with the byte count is accounted
                // first, so that the truncation flag reaches this byte count.
                if (s_we) begin
                    if (word_room) begin
                        d_we_nxt = 1'b1;
                        wcnt_nxt = wcnt + WCNT_W'(1);
                    end else begin
                        trunc_w = 1'b1;
                    end
                end
                trunc_nxt = trunc_w;

                if (s_bcnt_we) begin
                    b_we_nxt  = 1'b1;
                    b_din_nxt = (s_byte_cnt & ~BIT_TRUNC) | (trunc_w ? BIT_TRUNC : 32'h0);
                    state_nxt = ST_IDLE;
                    wcnt_nxt  = '0;
                    trunc_nxt = 1'b0;
                end else if (!linkup) begin
                    state_nxt = ST_ABORT;
                end
            end

            ST_ABORT: begin
                b_we_nxt  = 1'b1;
                b_din_nxt = BIT_LERR | (trunc ? BIT_TRUNC : 32'h0);
                wcnt_nxt  = '0;
                trunc_nxt = 1'b0;
                // The aborted packet's own byte count may already be here.
                if (s_bcnt_we) begin
                    drop_inc  = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_DROP;
                end
            end

            ST_DROP: begin
                if (s_bcnt_we) begin
                    drop_inc  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                wcnt_nxt  = '0;
                trunc_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state    <= ST_IDLE;
            wcnt     <= '0;
            trunc    <= 1'b0;
            d_we     <= 1'b0;
            d_dout   <= '0;
            c_dout   <= '0;
            b_we     <= 1'b0;
            b_din    <= '0;
            drop_cnt <= '0;
            busy     <= 1'b0;
        end else begin
            state  <= state_nxt;
            wcnt   <= wcnt_nxt;
            trunc  <= trunc_nxt;
            d_we   <= d_we_nxt;
            d_dout <= s_data;
            c_dout <= s_ctrl;
            b_we   <= b_we_nxt;
            b_din  <= b_din_nxt;
            busy   <= (state_nxt != ST_IDLE);
            if (drop_inc && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

`ifdef X2C_STATS_EN
    logic pass_inc;
    logic trunc_inc;

    assign pass_inc  = b_we_nxt & ~b_din_nxt[16] & ~b_din_nxt[17];
    assign trunc_inc = b_we_nxt & (b_din_nxt[16] | b_din_nxt[17]);

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            pass_cnt  <= '0;
            trunc_cnt <= '0;
        end else begin
            if (pass_inc) begin
                pass_cnt <= pass_cnt + 32'd1;
            end
            if (trunc_inc && (trunc_cnt != 16'hFFFF)) begin
                trunc_cnt <= trunc_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_x2c_wr_ctrl.sv
module tb_x2c_wr_ctrl;

    logic         clk = 1'b0;
    logic         reset_;
    logic         linkup;
    logic         s_we;
    logic [255:0] s_data;
    logic [31:0]  s_ctrl;
    logic         s_bcnt_we;
    logic [31:0]  s_byte_cnt;
    logic [8:0]   d_free;
    logic         b_full;
    logic         d_we;
    logic [255:0] d_dout;
    logic [31:0]  c_dout;
    logic         b_we;
    logic [31:0]  b_din;
    logic [15:0]  drop_cnt;
    logic         busy;
`ifdef X2C_STATS_EN
    logic [31:0]  pass_cnt;
    logic [15:0]  trunc_cnt;
`endif

    x2c_wr_ctrl #(.MAX_PKT_WORDS(48), .FREE_W(9)) dut (
        .clk        (clk),
        .reset_     (reset_),
        .linkup     (linkup),
        .s_we       (s_we),
        .s_data     (s_data),
        .s_ctrl     (s_ctrl),
        .s_bcnt_we  (s_bcnt_we),
        .s_byte_cnt (s_byte_cnt),
        .d_free     (d_free),
        .b_full     (b_full),
        .d_we       (d_we),
        .d_dout     (d_dout),
        .c_dout     (c_dout),
        .b_we       (b_we),
        .b_din      (b_din),
        .drop_cnt   (drop_cnt),
        .busy       (busy)
`ifdef X2C_STATS_EN
        ,
        .pass_cnt   (pass_cnt),
        .trunc_cnt  (trunc_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [255:0] d;
        logic [31:0]  c;
        int           t;
    } dexp_t;

    typedef struct {
        logic [31:0] b;
        int          t;
    } bexp_t;

    dexp_t dq[$];
    bexp_t bq[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] mkdata(input int p, input int w);
        logic [31:0] pw;
        pw = {p[15:0], w[15:0]};
        return {8{pw}};
    endfunction

    function automatic logic [31:0] mkctrl(input int p, input int w);
        return {p[15:0], w[15:0]} ^ 32'hA5A5_0000;
    endfunction

    // Monitor: pops the scoreboard whenever the DUT writes a FIFO.
    dexp_t de;
    bexp_t be;
    always @(negedge clk) begin
        if (reset_) begin
            if (d_we) begin
                if (dq.size() == 0) begin
                    chk("d_we_unexpected", 64'(d_we), 64'd0);
                end else begin
                    de = dq.pop_front();
                    chk("d_dout", 64'(d_dout[63:0]), 64'(de.d[63:0]));
                    chk("d_dout_hi", 64'(d_dout[255:192]), 64'(de.d[255:192]));
                    chk("c_dout", 64'(c_dout), 64'(de.c));
                    chk("d_latency", 64'(cyc), 64'(de.t));
                end
            end
            if (b_we) begin
                if (bq.size() == 0) begin
                    chk("b_we_unexpected", 64'(b_we), 64'd0);
                end else begin
                    be = bq.pop_front();
                    chk("b_din", 64'(b_din), 64'(be.b));
                    chk("b_latency", 64'(cyc), 64'(be.t));
                end
            end
        end
    end

    // Drives one input cycle; expectations are pushed with the cycle at
    // which the registered write must be seen.
    task automatic send(input bit we, input bit bv, input logic [31:0] bc,
                        input int p, input int w,
                        input bit ed, input bit eb, input logic [31:0] ebdin);
        dexp_t d;
        bexp_t b;
        s_we       = we;
        s_bcnt_we  = bv;
        s_byte_cnt = bc;
        s_data     = mkdata(p, w);
        s_ctrl     = mkctrl(p, w);
        if (ed) begin
            d.d = s_data; d.c = s_ctrl; d.t = cyc + 1;
            dq.push_back(d);
        end
        if (eb) begin
            b.b = ebdin; b.t = cyc + 1;
            bq.push_back(b);
        end
        @(posedge clk);
        #1;
        s_we      = 1'b0;
        s_bcnt_we = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog time limit expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        bexp_t b;
        reset_     = 1'b0;
        linkup     = 1'b0;
        s_we       = 1'b0;
        s_bcnt_we  = 1'b0;
        s_byte_cnt = '0;
        s_data     = '0;
        s_ctrl     = '0;
        d_free     = 9'd0;
        b_full     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_d_we", 64'(d_we), 64'd0);
        chk("rst_b_we", 64'(b_we), 64'd0);
        chk("rst_b_din", 64'(b_din), 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        reset_ = 1'b1;
        linkup = 1'b1;
        d_free = 9'd100;
        idle(2);

        // 5-word packet, byte count in a separate cycle.
        for (int w = 1; w <= 5; w++) begin
            send(1, 0, 0, 1, w, 1, 0, 0);
            if (w == 3) chk("busy_in_pass", 64'(busy), 64'd1);
        end
        send(0, 1, 32'h0100_00A0, 1, 0, 0, 1, 32'h0100_00A0);
        chk("busy_after_pass", 64'(busy), 64'd0);
        chk("drop_cnt_0", 64'(drop_cnt), 64'd0);
        idle(2);

        // Insufficient free space one below the reserve: dropped.
        d_free = 9'd47;
        for (int w = 1; w <= 3; w++) send(1, 0, 0, 2, w, 0, 0, 0);
        d_free = 9'd100;
        send(0, 1, 32'h0100_0060, 2, 0, 0, 0, 0);
        chk("drop_cnt_1", 64'(drop_cnt), 64'd1);

        // Exactly the reserve: admitted; byte count with the last word.
        d_free = 9'd48;
        send(1, 0, 0, 3, 1, 1, 0, 0);
        send(1, 1, 32'h0200_0040, 3, 2, 1, 1, 32'h0200_0040);
        idle(2);

        // 50-word packet truncated to 48 words.
        d_free = 9'd200;
        for (int w = 1; w <= 50; w++) send(1, 0, 0, 4, w, (w <= 48), 0, 0);
        send(0, 1, 32'h0300_0640, 4, 0, 0, 1, 32'h0301_0640);
        chk("busy_after_trunc", 64'(busy), 64'd0);
        idle(2);

        // Link loss after word 3.
        d_free = 9'd100;
        for (int w = 1; w <= 3; w++) send(1, 0, 0, 5, w, 1, 0, 0);
        linkup = 1'b0;
        b.b = 32'h0002_0000; b.t = cyc + 2;
        bq.push_back(b);
        idle(1);
        idle(1);
        send(1, 0, 0, 5, 4, 0, 0, 0);
        send(1, 0, 0, 5, 5, 0, 0, 0);
        chk("busy_in_drop", 64'(busy), 64'd1);
        send(0, 1, 32'h0100_00A0, 5, 0, 0, 0, 0);
        chk("drop_cnt_abort", 64'(drop_cnt), 64'd2);
        linkup = 1'b1;
        idle(2);

        // 1-word packet passed.
        send(1, 1, 32'h0100_0020, 6, 1, 1, 1, 32'h0100_0020);
        chk("busy_1word", 64'(busy), 64'd0);
        idle(1);

        // 1-word packet dropped on b_full.
        b_full = 1'b1;
        send(1, 1, 32'h0100_0020, 7, 1, 0, 0, 0);
        chk("busy_1word_drop", 64'(busy), 64'd0);
        chk("drop_cnt_bfull", 64'(drop_cnt), 64'd3);

        // Saturation of drop_cnt.
        for (int i = 0; i < 65531; i++) send(1, 1, 0, 8, 1, 0, 0, 0);
        chk("drop_cnt_fffe", 64'(drop_cnt), 64'hFFFE);
        send(1, 1, 0, 8, 1, 0, 0, 0);
        chk("drop_cnt_ffff", 64'(drop_cnt), 64'hFFFF);
        for (int i = 0; i < 5; i++) send(1, 1, 0, 8, 1, 0, 0, 0);
        chk("drop_cnt_hold", 64'(drop_cnt), 64'hFFFF);
        b_full = 1'b0;
        idle(2);

        // Asynchronous reset in the middle of an admitted packet.
        send(1, 0, 0, 9, 1, 1, 0, 0);
        send(1, 0, 0, 9, 2, 1, 0, 0);
        s_we   = 1'b1;
        s_data = mkdata(9, 3);
        s_ctrl = mkctrl(9, 3);
        #6;
        reset_ = 1'b0;
        s_we   = 1'b0;
        #1;
        chk("arst_d_we", 64'(d_we), 64'd0);
        chk("arst_d_dout", 64'(d_dout[63:0]), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_drop_cnt", 64'(drop_cnt), 64'd0);
        @(posedge clk);
        #1;
        reset_ = 1'b1;
        idle(1);

        // Clean packet after reset: state back in IDLE.
        send(1, 0, 0, 10, 1, 1, 0, 0);
        send(1, 1, 32'h0000_0010, 10, 2, 1, 1, 32'h0000_0010);
        idle(4);
        chk("dq_empty", 64'(dq.size()), 64'd0);
        chk("bq_empty", 64'(bq.size()), 64'd0);
        chk("drop_cnt_final", 64'(drop_cnt), 64'd0);
`ifdef X2C_STATS_EN
        chk("pass_cnt", 64'(pass_cnt), 64'd1);
        chk("trunc_cnt", 64'(trunc_cnt), 64'd0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
